// File: rtl/apb_arbiter_rr2_pkg.sv
// Types and helpers for the two-master round-robin APB arbiter.
package apb_arbiter_rr2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } t_arb_state;

  localparam logic OWNER_0 = 1'b0;
  localparam logic OWNER_1 = 1'b1;

  // Master 1 wins when it is the only requester, or on contention when master 0 went last.
  function automatic logic pick_grant(input logic psel_0, input logic psel_1,
                                      input logic last_owner);
    return psel_1 & (!psel_0 | !last_owner);
  endfunction

endpackage

// File: rtl/apb_pkg.sv
// Shared APB request/response bundles used across the peripheral fabric.
package apb_pkg;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } t_apb_request;

  typedef struct packed {
    logic        pready;
    logic        perr;
    logic [31:0] prdata;
  } t_apb_response;

endpackage

// File: rtl/apb_arbiter_rr2.sv
// Two-master round-robin APB arbiter with registered target request and optional access timeout.
module apb_arbiter_rr2
  import apb_pkg::*;
  import apb_arbiter_rr2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset,
  input  logic        apb_request_0__psel,
  input  logic        apb_request_0__penable,
  input  logic        apb_request_0__pwrite,
  input  logic [31:0] apb_request_0__paddr,
  input  logic [31:0] apb_request_0__pwdata,
  output logic        apb_response_0__pready,
  output logic        apb_response_0__perr,
  output logic [31:0] apb_response_0__prdata,
  input  logic        apb_request_1__psel,
  input  logic        apb_request_1__penable,
  input  logic        apb_request_1__pwrite,
  input  logic [31:0] apb_request_1__paddr,
  input  logic [31:0] apb_request_1__pwdata,
  output logic        apb_response_1__pready,
  output logic        apb_response_1__perr,
  output logic [31:0] apb_response_1__prdata,
  output logic        apb_request__psel,
  output logic        apb_request__penable,
  output logic        apb_request__pwrite,
  output logic [31:0] apb_request__paddr,
  output logic [31:0] apb_request__pwdata,
  input  logic        apb_response__pready,
  input  logic        apb_response__perr,
  input  logic [31:0] apb_response__prdata,
  output logic        busy,
  output logic        owner
);

  localparam bit                     TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  t_apb_request  m_req_0, m_req_1;
  t_apb_response tgt_rsp;

  t_arb_state               state_q, state_d;
  t_apb_request             req_q, req_d;
  logic                     owner_q, owner_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  t_apb_response            rsp_fwd, rsp_0, rsp_1;
  logic                     grant;
  logic                     done;

  assign m_req_0 = '{psel: apb_request_0__psel, penable: apb_request_0__penable,
                     pwrite: apb_request_0__pwrite, paddr: apb_request_0__paddr,
                     pwdata: apb_request_0__pwdata};
  assign m_req_1 = '{psel: apb_request_1__psel, penable: apb_request_1__penable,
                     pwrite: apb_request_1__pwrite, paddr: apb_request_1__paddr,
                     pwdata: apb_request_1__pwdata};
  assign tgt_rsp = '{pready: apb_response__pready, perr: apb_response__perr,
                     prdata: apb_response__prdata};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    rsp_fwd = '0;
    rsp_0   = '0;
    rsp_1   = '0;
    done    = 1'b0;
    grant   = pick_grant(m_req_0.psel, m_req_1.psel, owner_q);

    unique case (state_q)
      IDLE: begin
        if (m_req_0.psel || m_req_1.psel) begin
          owner_d       = grant;
          req_d         = (grant == OWNER_1) ? m_req_1 : m_req_0;
          req_d.psel    = 1'b1;
          req_d.penable = 1'b0;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        req_d.penable = 1'b1;
        cnt_d         = '0;
        state_d       = ACCESS;
      end
      ACCESS: begin
        // Target completion takes priority over a coincident timeout expiry.
        if (tgt_rsp.pready) begin
          rsp_fwd = tgt_rsp;
          done    = 1'b1;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rsp_fwd = '{pready: 1'b1, perr: 1'b1, prdata: 32'h0};
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (done) begin
          req_d.psel    = 1'b0;
          req_d.penable = 1'b0;
          state_d       = IDLE;
        end
        if (owner_q == OWNER_1) rsp_1 = rsp_fwd;
        else                    rsp_0 = rsp_fwd;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      owner_q <= OWNER_1;
      cnt_q   <= '0;
    end else if (clk__enable) begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign apb_request__psel      = req_q.psel;
  assign apb_request__penable   = req_q.penable;
  assign apb_request__pwrite    = req_q.pwrite;
  assign apb_request__paddr     = req_q.paddr;
  assign apb_request__pwdata    = req_q.pwdata;
  assign apb_response_0__pready = rsp_0.pready;
  assign apb_response_0__perr   = rsp_0.perr;
  assign apb_response_0__prdata = rsp_0.prdata;
  assign apb_response_1__pready = rsp_1.pready;
  assign apb_response_1__perr   = rsp_1.perr;
  assign apb_response_1__prdata = rsp_1.prdata;
  assign busy                   = (state_q != IDLE);
  assign owner                  = owner_q;

endmodule

// File: tb/tb_apb_arbiter_rr2.sv
// Directed bench: one arbiter with timeout disabled and one with TIMEOUT_CYCLES=4, sharing stimulus.
module tb_apb_arbiter_rr2;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       m_psel = '0, m_penable = '0, m_pwrite = '0;
  logic [1:0][31:0] m_paddr = '0, m_pwdata = '0;
  logic             tgt_pready = 1'b0, tgt_perr = 1'b0;
  logic [31:0]      tgt_prdata = '0;

  logic [1:0]       a_pready, a_perr, b_pready, b_perr;
  logic [1:0][31:0] a_prdata, b_prdata;
  logic             a_tpsel, a_tpenable, a_tpwrite, a_busy, a_owner;
  logic             b_tpsel, b_tpenable, b_tpwrite, b_busy, b_owner;
  logic [31:0]      a_tpaddr, a_tpwdata, b_tpaddr, b_tpwdata;

  apb_arbiter_rr2 #(.TIMEOUT_CYCLES(0), .TIMEOUT_WIDTH(16)) dut_a (
    .clk(clk), .clk__enable(clk_en), .reset(reset),
    .apb_request_0__psel(m_psel[0]), .apb_request_0__penable(m_penable[0]),
    .apb_request_0__pwrite(m_pwrite[0]), .apb_request_0__paddr(m_paddr[0]),
    .apb_request_0__pwdata(m_pwdata[0]),
    .apb_response_0__pready(a_pready[0]), .apb_response_0__perr(a_perr[0]),
    .apb_response_0__prdata(a_prdata[0]),
    .apb_request_1__psel(m_psel[1]), .apb_request_1__penable(m_penable[1]),
    .apb_request_1__pwrite(m_pwrite[1]), .apb_request_1__paddr(m_paddr[1]),
    .apb_request_1__pwdata(m_pwdata[1]),
    .apb_response_1__pready(a_pready[1]), .apb_response_1__perr(a_perr[1]),
    .apb_response_1__prdata(a_prdata[1]),
    .apb_request__psel(a_tpsel), .apb_request__penable(a_tpenable),
    .apb_request__pwrite(a_tpwrite), .apb_request__paddr(a_tpaddr),
    .apb_request__pwdata(a_tpwdata),
    .apb_response__pready(tgt_pready), .apb_response__perr(tgt_perr),
    .apb_response__prdata(tgt_prdata),
    .busy(a_busy), .owner(a_owner)
  );

  apb_arbiter_rr2 #(.TIMEOUT_CYCLES(4), .TIMEOUT_WIDTH(16)) dut_b (
    .clk(clk), .clk__enable(clk_en), .reset(reset),
    .apb_request_0__psel(m_psel[0]), .apb_request_0__penable(m_penable[0]),
    .apb_request_0__pwrite(m_pwrite[0]), .apb_request_0__paddr(m_paddr[0]),
    .apb_request_0__pwdata(m_pwdata[0]),
    .apb_response_0__pready(b_pready[0]), .apb_response_0__perr(b_perr[0]),
    .apb_response_0__prdata(b_prdata[0]),
    .apb_request_1__psel(m_psel[1]), .apb_request_1__penable(m_penable[1]),
    .apb_request_1__pwrite(m_pwrite[1]), .apb_request_1__paddr(m_paddr[1]),
    .apb_request_1__pwdata(m_pwdata[1]),
    .apb_response_1__pready(b_pready[1]), .apb_response_1__perr(b_perr[1]),
    .apb_response_1__prdata(b_prdata[1]),
    .apb_request__psel(b_tpsel), .apb_request__penable(b_tpenable),
    .apb_request__pwrite(b_tpwrite), .apb_request__paddr(b_tpaddr),
    .apb_request__pwdata(b_tpwdata),
    .apb_response__pready(tgt_pready), .apb_response__perr(tgt_perr),
    .apb_response__prdata(tgt_prdata),
    .busy(b_busy), .owner(b_owner)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int who, input logic [31:0] addr, input logic wr,
                     input logic [31:0] wdata);
    m_psel[who]   = 1'b1;
    m_pwrite[who] = wr;
    m_paddr[who]  = addr;
    m_pwdata[who] = wdata;
  endtask

  // Entered in the target SETUP cycle; returns in the IDLE cycle after completion.
  task automatic serve(input string tag, input int who, input int waits,
                       input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic terr);
    check({tag, "/setup_psel"}, a_tpsel, 1);
    check({tag, "/setup_pen"}, a_tpenable, 0);
    check({tag, "/owner"}, a_owner, who);
    check({tag, "/paddr"}, a_tpaddr, addr);
    check({tag, "/pwrite"}, a_tpwrite, wr);
    check({tag, "/pwdata"}, a_tpwdata, wdata);
    cyc();
    for (int w = 0; w < waits; w++) begin
      check({tag, "/wait_pen"}, a_tpenable, 1);
      check({tag, "/wait_rdy"}, a_pready[who], 0);
      check({tag, "/wait_addr"}, a_tpaddr, addr);
      check({tag, "/wait_wdata"}, a_tpwdata, wdata);
      cyc();
    end
    tgt_pready = 1'b1;
    tgt_prdata = rdata;
    tgt_perr   = terr;
    #1;
    check({tag, "/acc_pen"}, a_tpenable, 1);
    check({tag, "/rdy"}, a_pready[who], 1);
    check({tag, "/rdata"}, a_prdata[who], rdata);
    check({tag, "/perr"}, a_perr[who], terr);
    check({tag, "/other_rdy"}, a_pready[1-who], 0);
    check({tag, "/other_perr"}, a_perr[1-who], 0);
    check({tag, "/b_rdy"}, b_pready[who], 1);
    check({tag, "/b_perr"}, b_perr[who], terr);
    check({tag, "/b_rdata"}, b_prdata[who], rdata);
    cyc();
    tgt_pready  = 1'b0;
    tgt_prdata  = '0;
    tgt_perr    = 1'b0;
    m_psel[who] = 1'b0;
    #1;
    check({tag, "/end_busy"}, a_busy, 0);
    check({tag, "/end_psel"}, a_tpsel, 0);
    check({tag, "/end_other_rdy"}, a_pready[1-who], 0);
  endtask

  initial begin
    cyc();
    cyc();
    check("rst_busy", a_busy, 0);
    check("rst_owner", a_owner, 1);
    check("rst_psel", a_tpsel, 0);
    check("rst_paddr", a_tpaddr, 0);
    check("rst_rdy", {a_pready, b_pready}, 0);
    reset = 1'b0;

    // Lone master 0 read, zero-wait target.
    req(0, 32'h0000_0008, 1'b0, 32'h0);
    #1;
    check("t1_T_psel", a_tpsel, 0);
    cyc();
    serve("t1", 0, 0, 32'h0000_0008, 1'b0, 32'h0, 32'h1234_5678, 1'b0);

    // Master 1 write with three wait states; dut_b hits expiry together with pready.
    cyc();
    req(1, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
    cyc();
    serve("t2", 1, 3, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);

    // Contention after master 1 went last: 0 then 1.
    req(0, 32'h0000_0020, 1'b0, 32'h0);
    req(1, 32'h0000_0024, 1'b0, 32'h0);
    cyc();
    serve("t3a", 0, 0, 32'h0000_0020, 1'b0, 32'h0, 32'hA0A0_0001, 1'b0);
    cyc();
    serve("t3b", 1, 0, 32'h0000_0024, 1'b0, 32'h0, 32'hB0B0_0002, 1'b0);

    // Target error forwarded to the owner only.
    req(0, 32'h0000_0030, 1'b0, 32'h0);
    cyc();
    serve("t4", 0, 1, 32'h0000_0030, 1'b0, 32'h0, 32'h0BAD_0BAD, 1'b1);

    // Contention after master 0 went last: 1 then 0.
    req(0, 32'h0000_0044, 1'b0, 32'h0);
    req(1, 32'h0000_0040, 1'b1, 32'h5555_AAAA);
    cyc();
    serve("t5a", 1, 0, 32'h0000_0040, 1'b1, 32'h5555_AAAA, 32'h0, 1'b0);
    cyc();
    serve("t5b", 0, 0, 32'h0000_0044, 1'b0, 32'h0, 32'hC0C0_0003, 1'b0);

    // Hung target: dut_b aborts in the 4th access cycle, dut_a keeps waiting.
    req(0, 32'h0000_0050, 1'b0, 32'h0);
    tgt_prdata = 32'hAAAA_5555;
    cyc();
    cyc();
    check("to_acc1_rdy", b_pready[0], 0);
    cyc();
    cyc();
    check("to_acc3_rdy", b_pready[0], 0);
    cyc();
    check("to_rdy", b_pready[0], 1);
    check("to_perr", b_perr[0], 1);
    check("to_rdata", b_prdata[0], 0);
    check("to_other", b_pready[1], 0);
    check("to_a_rdy", a_pready[0], 0);
    cyc();
    m_psel[0] = 1'b0;
    #1;
    check("to_b_psel", b_tpsel, 0);
    check("to_b_busy", b_busy, 0);
    check("to_a_busy", a_busy, 1);
    cyc();
    cyc();
    check("noto_a_rdy", a_pready[0], 0);
    check("noto_a_psel", a_tpsel, 1);

    // Asynchronous reset while dut_a sits in ACCESS with pready asserted.
    tgt_pready = 1'b1;
    tgt_prdata = 32'h0000_1111;
    #1;
    check("arst_pre_rdy", a_pready[0], 1);
    reset = 1'b1;
    #1;
    check("arst_rdy", a_pready[0], 0);
    check("arst_rdata", a_prdata[0], 0);
    check("arst_psel", a_tpsel, 0);
    check("arst_pen", a_tpenable, 0);
    check("arst_busy", a_busy, 0);
    check("arst_owner", a_owner, 1);
    tgt_pready = 1'b0;
    tgt_prdata = '0;
    cyc();
    cyc();
    reset = 1'b0;

    // First contention after reset goes to master 0.
    req(0, 32'h0000_0060, 1'b0, 32'h0);
    req(1, 32'h0000_0064, 1'b0, 32'h0);
    cyc();
    serve("t7a", 0, 0, 32'h0000_0060, 1'b0, 32'h0, 32'hD0D0_0004, 1'b0);
    cyc();
    serve("t7b", 1, 0, 32'h0000_0064, 1'b0, 32'h0, 32'hE0E0_0005, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
